// File: rtl/frame_ptr_ctrl.sv
// Triple-buffer frame slot arbiter between one writer and one reader.
// Optional statistics counters compile in with FRAME_PTR_CTRL_STAT_EN.
module frame_ptr_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 'h3fff0000,
  parameter int unsigned FRAME_SIZE = 4147200,
  parameter int unsigned FRAMES_AMOUNT = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_done_stb_i,
  input  logic                  rd_start_stb_i,
  output logic [2:0]            wr_slot_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [2:0]            rd_slot_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  rd_valid_o,
  output logic [15:0]           drop_cnt_o,
  output logic [15:0]           repeat_cnt_o
);

  function automatic logic [ADDR_WIDTH-1:0] slot_addr(
    input logic [2:0] s
  );
    return START_ADDR
      + ADDR_WIDTH'(s) * ADDR_WIDTH'(FRAME_SIZE);
  endfunction

  function automatic logic [2:0] pick(
    input logic [2:0] a,
    input logic [2:0] b
  );
    logic [2:0] p;
    logic found;
    p = '0;
    found = 1'b0;
    for (int i = 0; i < FRAMES_AMOUNT; i++) begin
      if (!found && 3'(i) != a && 3'(i) != b) begin
        p = 3'(i);
        found = 1'b1;
      end
    end
    return p;
  endfunction

  logic       sync1, ready;
  logic [2:0] w_q, r_q, l_q;
  logic       lv_q;
  logic [2:0] w_nx, r_nx, l_nx;
  logic       lv_nx, rv_nx;
  logic       wd, rs;

  // Strobes are ignored until the release has passed two flops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1 <= 1'b0;
      ready <= 1'b0;
    end else begin
      sync1 <= 1'b1;
      ready <= sync1;
    end
  end

  assign wd = wr_done_stb_i & ready;
  assign rs = rd_start_stb_i & ready;

  always_comb begin
    w_nx  = w_q;
    r_nx  = r_q;
    l_nx  = l_q;
    lv_nx = lv_q;
    rv_nx = rd_valid_o;
    unique case (1'b1)
      wd && rs: begin
        r_nx  = w_q;
        l_nx  = w_q;
        lv_nx = 1'b0;
        rv_nx = 1'b1;
        w_nx  = pick(w_q, w_q);
      end
      wd && !rs: begin
        l_nx  = w_q;
        lv_nx = 1'b1;
        w_nx  = pick(r_q, w_q);
      end
      !wd && rs && lv_q: begin
        r_nx  = l_q;
        lv_nx = 1'b0;
        rv_nx = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_q        <= 3'd0;
      r_q        <= 3'd1;
      l_q        <= 3'd0;
      lv_q       <= 1'b0;
      rd_valid_o <= 1'b0;
      wr_addr_o  <= slot_addr(3'd0);
      rd_addr_o  <= slot_addr(3'd1);
    end else begin
      w_q        <= w_nx;
      r_q        <= r_nx;
      l_q        <= l_nx;
      lv_q       <= lv_nx;
      rd_valid_o <= rv_nx;
      wr_addr_o  <= slot_addr(w_nx);
      rd_addr_o  <= slot_addr(r_nx);
    end
  end

  assign wr_slot_o = w_q;
  assign rd_slot_o = r_q;

`ifdef FRAME_PTR_CTRL_STAT_EN
  logic [15:0] drop_q, rep_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_q <= '0;
      rep_q  <= '0;
    end else begin
      if (wd && lv_q && drop_q != 16'hffff)
        drop_q <= drop_q + 16'd1;
      if (rs && !lv_q && rep_q != 16'hffff)
        rep_q <= rep_q + 16'd1;
    end
  end

  assign drop_cnt_o   = drop_q;
  assign repeat_cnt_o = rep_q;
`else
  assign drop_cnt_o   = '0;
  assign repeat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_frame_ptr_ctrl.sv
// Directed bench for frame_ptr_ctrl; counter expectations
// follow FRAME_PTR_CTRL_STAT_EN.
module tb_frame_ptr_ctrl;

`ifdef FRAME_PTR_CTRL_STAT_EN
  localparam int STAT = 1;
`else
  localparam int STAT = 0;
`endif

  localparam logic [31:0] A0 = 32'h3fff0000;
  localparam logic [31:0] A1 = 32'h403e4800;
  localparam logic [31:0] A2 = 32'h407d9000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_done = 1'b0;
  logic        rd_start = 1'b0;
  logic [2:0]  wr_slot, rd_slot;
  logic [31:0] wr_addr, rd_addr;
  logic        rd_valid;
  logic [15:0] drop_cnt, repeat_cnt;

  int compared = 0;
  int mismatched = 0;

  frame_ptr_ctrl dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .wr_done_stb_i (wr_done),
    .rd_start_stb_i(rd_start),
    .wr_slot_o     (wr_slot),
    .wr_addr_o     (wr_addr),
    .rd_slot_o     (rd_slot),
    .rd_addr_o     (rd_addr),
    .rd_valid_o    (rd_valid),
    .drop_cnt_o    (drop_cnt),
    .repeat_cnt_o  (repeat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic wd, input logic rs);
    @(posedge clk);
    #1 wr_done = wd;
    rd_start = rs;
    @(posedge clk);
    #1 wr_done = 1'b0;
    rd_start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wslot"}, 32'(wr_slot), 32'd0);
    check({tag, "_waddr"}, wr_addr, A0);
    check({tag, "_rslot"}, 32'(rd_slot), 32'd1);
    check({tag, "_raddr"}, rd_addr, A1);
    check({tag, "_rvalid"}, 32'(rd_valid), 32'd0);
    check({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    check({tag, "_rep"}, 32'(repeat_cnt), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wr_done = 1'b1;
    @(posedge clk);
    #1 wr_done = 1'b0;
    check("sync_ignore", 32'(wr_slot), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("inv_w_r", 32'(wr_slot != rd_slot), 32'd1);
      if (dut.lv_q)
        check("inv_w_l", 32'(wr_slot != dut.l_q), 32'd1);
    end
  end

  initial begin
    wr_done = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset("rst");
    release_reset();

    pulse(1'b1, 1'b0);
    check("w1_slot", 32'(wr_slot), 32'd2);
    check("w1_addr", wr_addr, A2);
    pulse(1'b1, 1'b0);
    check("w2_slot", 32'(wr_slot), 32'd0);
    pulse(1'b1, 1'b0);
    check("w3_slot", 32'(wr_slot), 32'd2);
    check("w3_drop", 32'(drop_cnt), 32'(2 * STAT));
    check("w3_rv", 32'(rd_valid), 32'd0);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_rst");
    repeat (2) @(posedge clk);
    release_reset();

    pulse(1'b1, 1'b0);
    check("a_wslot", 32'(wr_slot), 32'd2);
    check("a_waddr", wr_addr, A2);
    pulse(1'b0, 1'b1);
    check("a_rslot", 32'(rd_slot), 32'd0);
    check("a_raddr", rd_addr, A0);
    check("a_rvalid", 32'(rd_valid), 32'd1);
    check("a_rep", 32'(repeat_cnt), 32'd0);

    pulse(1'b0, 1'b1);
    check("rep_rslot", 32'(rd_slot), 32'd0);
    check("rep_cnt", 32'(repeat_cnt), 32'(STAT));
    check("rep_rv", 32'(rd_valid), 32'd1);

    pulse(1'b1, 1'b0);
    check("b_wslot", 32'(wr_slot), 32'd1);
    check("b_waddr", wr_addr, A1);
    pulse(1'b1, 1'b0);
    check("c_wslot", 32'(wr_slot), 32'd2);
    check("c_drop", 32'(drop_cnt), 32'(STAT));

    pulse(1'b1, 1'b1);
    check("both_rslot", 32'(rd_slot), 32'd2);
    check("both_raddr", rd_addr, A2);
    check("both_wslot", 32'(wr_slot), 32'd0);
    check("both_waddr", wr_addr, A0);
    check("both_rv", 32'(rd_valid), 32'd1);
    check("both_drop", 32'(drop_cnt), 32'(2 * STAT));

    pulse(1'b0, 1'b1);
    check("d_rslot", 32'(rd_slot), 32'd2);
    check("d_rep", 32'(repeat_cnt), 32'(2 * STAT));

    @(posedge clk);
    #1 wr_done = 1'b1;
    repeat (2) @(posedge clk);
    #1 wr_done = 1'b0;
    check("hold_wslot", 32'(wr_slot), 32'd0);
    check("hold_drop", 32'(drop_cnt), 32'(3 * STAT));
    check("hold_rslot", 32'(rd_slot), 32'd2);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/frame_ptr_ctrl.md
FRAME_PTR_CTRL -- requirements
Module: frame_ptr_ctrl

Interface
REQ-001 The block SHALL have parameter START_ADDR, default 32'h3fff0000, byte address of frame slot 0.
REQ-002 The block SHALL have parameter FRAME_SIZE, default 4147200, bytes per slot (1920x1080x2).
REQ-003 The block SHALL have parameter FRAMES_AMOUNT, default 3, number of slots; legal range 3..8.
REQ-004 The block SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-005 The block SHALL have port clk_i, input, 1, the single clock; reset is asynchronous and active-low.
REQ-006 The block SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port wr_done_stb_i, input, 1, one-cycle strobe: writer finished the current slot.
REQ-008 The block SHALL have port rd_start_stb_i, input, 1, one-cycle strobe: reader begins a new frame.
REQ-009 The block SHALL have port wr_slot_o, output, 3, slot the writer owns.
REQ-010 The block SHALL have port wr_addr_o, output, ADDR_WIDTH, base address of wr_slot_o.
REQ-011 The block SHALL have port rd_slot_o, output, 3, slot the reader owns.
REQ-012 The block SHALL have port rd_addr_o, output, ADDR_WIDTH, base address of rd_slot_o.
REQ-013 The block SHALL have port rd_valid_o, output, 1, rd_slot_o holds a completely written frame.
REQ-014 The block SHALL have ports drop_cnt_o and repeat_cnt_o, output, 16 each, statistics (REQ-029).

Function
REQ-015 State: W (writer slot), R (reader slot), L (latest completed slot) plus l_valid flag; all registered; outputs update one cycle after a strobe.
REQ-016 On wr_done_stb_i: L <= W, l_valid <= 1; W <= lowest-index slot distinct from new R and new L.
REQ-017 On rd_start_stb_i with l_valid=1: R <= L, l_valid <= 0, rd_valid_o <= 1.
REQ-018 On rd_start_stb_i with l_valid=0: R unchanged (frame repeat); rd_valid_o unchanged.
REQ-019 Simultaneous strobes: R <= old W, L <= old W, l_valid <= 0, rd_valid_o <= 1, W <= lowest slot distinct from old W; old L, if valid, is dropped.
REQ-020 Invariant: W != R at all times; W != L while l_valid=1.
REQ-021 slot_addr = START_ADDR + slot*FRAME_SIZE, computed modulo 2^ADDR_WIDTH; wr_addr_o/rd_addr_o registered with their slot.
REQ-022 wr_done_stb_i held high N cycles SHALL be treated as N strobes; no edge detection.

Reset
REQ-023 rst_n_i low SHALL asynchronously force W=0, R=1, l_valid=0, rd_valid_o=0, counters=0.
REQ-024 After reset wr_addr_o=START_ADDR, rd_addr_o=START_ADDR+FRAME_SIZE.
REQ-025 Reset asserted mid-operation SHALL discard all slot ownership; strobes during reset ignored.
REQ-026 Reset release SHALL be synchronised internally so the first strobe is honoured no earlier than the second clk_i edge after deassertion.

Configuration
REQ-027 Macro FRAME_PTR_CTRL_STAT_EN SHALL compile the statistics counters in or out.
REQ-028 Without the macro, drop_cnt_o and repeat_cnt_o SHALL be tied to 0 and no counter flops exist.
REQ-029 With the macro: drop_cnt_o +1 on each wr_done_stb_i while l_valid=1 (including REQ-019 case); repeat_cnt_o +1 on each rd_start_stb_i while l_valid=0; both saturate at 16'hffff.

Verification
REQ-030 Reset, defaults -> wr_slot_o=0, wr_addr_o=32'h3fff0000, rd_slot_o=1, rd_addr_o=32'h403e4800, rd_valid_o=0.
REQ-031 One wr_done_stb_i then rd_start_stb_i -> after first: wr_slot_o=2, wr_addr_o=32'h407d9000; after second: rd_slot_o=0, rd_addr_o=32'h3fff0000, rd_valid_o=1.
REQ-032 Three wr_done_stb_i, no reads -> W cycles 0->2->0->2, drop_cnt_o=2 (macro on) or 0 (macro off).
REQ-033 Both strobes in one cycle from state W=2,R=0,l_valid=1 (L=1) -> rd_slot_o=2, wr_slot_o=0, rd_valid_o=1, drop_cnt_o +1.
REQ-034 Two rd_start_stb_i with no write in between -> rd_slot_o unchanged, repeat_cnt_o +1 on the second.
REQ-035 rst_n_i low mid-frame with l_valid=1 -> outputs return to REQ-030 values without a clock edge; invariant REQ-020 checked by assertion every cycle.
